fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage, directly upstream of the immediate generator and decode.
- Holds the PC and issues one instruction-memory request at a time. Registers the returned 32-bit instruction.
- Pre-decodes the opcode into the one-hot inst_type vector that the immediate generator consumes.
- Presents instruction, pc and inst_type to decode through a valid/ready handshake. Supports redirect from branch/jump resolution.

Parameters:
LEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_req  out  1  instruction-memory request, held until granted
mem_addr  out  LEN  request address (= pc)
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  read data valid (arrives ≥1 cycle after gnt)
mem_rdata  in  LEN  fetched instruction
redirect_valid  in  1  pipeline redirect (taken branch/jump)
redirect_pc  in  LEN  redirect target
id_valid  out  1  instruction register holds a valid instruction
id_ready  in  1  decode accepts instruction this cycle
instruction  out  LEN  registered instruction
pc_out  out  LEN  address of the registered instruction
inst_type  out  6  one-hot: R=000001 I=000010 S=000100 B=001000 U=010000 J=100000
illegal  out  1  opcode unrecognised (inst_type=000000)

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, mem_req=0, id_valid=0, instruction=0, pc_out=0, inst_type=0, illegal=0.
- FSM states: IDLE, REQ, WAIT, FULL, DRAIN.
- IDLE: next cycle → REQ. First mem_req is in cycle 1 after reset release.
- REQ:
  - mem_req=1, mem_addr=pc.
  - On mem_gnt → WAIT.
  - mem_addr must stay stable until gnt.
- WAIT:
  - On mem_rvalid: latch mem_rdata→instruction, pc→pc_out, pre-decoded type→inst_type/illegal. Set id_valid=1, pc+=4 (wraps mod 2^LEN), → FULL.
- FULL:
  - Output held stable while id_valid & !id_ready.
  - On id_ready: → REQ, id_valid=0 next cycle.
  - At most one instruction in flight. Throughput is one instruction per ≥3 cycles; this is accepted.
- Redirect (priority over all other transitions, any state except IDLE):
  - pc←redirect_pc, id_valid←0 next cycle.
  - Redirect in WAIT, or in REQ with mem_gnt the same cycle → DRAIN. The outstanding response is discarded.
  - Redirect in WAIT with mem_rvalid the same cycle: data discarded, → REQ.
  - Otherwise → REQ; an ungranted old request is withdrawn.
- DRAIN: on mem_rvalid discard the data, → REQ. A redirect in DRAIN only updates pc; the state stays DRAIN.
- Pre-decode on mem_rdata[6:0]:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - else → inst_type=0, illegal=1
- inst_type is always one-hot or zero, never multi-hot.
- mem_rvalid outside WAIT/DRAIN is ignored.
- mem_gnt outside REQ is ignored.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants
  - INST_TYPE_R..J one-hot constants, identical to those the immediate generator decodes
  - FSM state enum
- One sub-module `inst_predecode`: combinational opcode → {inst_type, illegal}. Reusable by the decode stage.

Test Plan:
- Reset release, RESET_PC=0, mem_gnt=1 immediately, rvalid one cycle later with 32'h00500093 (addi) → id_valid=1, inst_type=000010, pc_out=0; next mem_addr=4.
- Hold id_ready=0 for 5 cycles in FULL → instruction/pc_out/inst_type stable, mem_req=0; id_ready=1 → mem_req next cycle with addr=4.
- mem_gnt withheld for 3 cycles → mem_req and mem_addr held constant; no state change.
- Redirect to 32'h100 while in WAIT; stale rvalid returns 32'hDEADBEEF → discarded, id_valid stays 0, next mem_addr=32'h100.
- Feed opcodes 0100011, 1100011, 0110111, 1101111, 0110011, 0000000 → inst_type 000100, 001000, 010000, 100000, 000001, 000000 with illegal=1 only on the last.
- Assert rst mid-WAIT → all outputs zero immediately (async), pc=RESET_PC; a late rvalid after reset release is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, one-hot instruction-type codes, fetch FSM states.
// Combinational constants only; no latency or backpressure involved.
package cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Same encoding the immediate generator decodes.
  localparam logic [5:0] INST_TYPE_R = 6'b000001;
  localparam logic [5:0] INST_TYPE_I = 6'b000010;
  localparam logic [5:0] INST_TYPE_S = 6'b000100;
  localparam logic [5:0] INST_TYPE_B = 6'b001000;
  localparam logic [5:0] INST_TYPE_U = 6'b010000;
  localparam logic [5:0] INST_TYPE_J = 6'b100000;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_FULL,
    FS_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/inst_predecode.sv
// Opcode pre-decode into one-hot instruction type plus illegal flag.
// Purely combinational, zero latency; no backpressure.
module inst_predecode
  import cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [5:0] inst_type_o,
  output logic       illegal_o
);

  always_comb begin
    inst_type_o = '0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OPC_OP:                                       inst_type_o = INST_TYPE_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:   inst_type_o = INST_TYPE_I;
      OPC_STORE:                                    inst_type_o = INST_TYPE_S;
      OPC_BRANCH:                                   inst_type_o = INST_TYPE_B;
      OPC_LUI, OPC_AUIPC:                           inst_type_o = INST_TYPE_U;
      OPC_JAL:                                      inst_type_o = INST_TYPE_J;
      default:                                      illegal_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch with opcode pre-decode; >=3 cycles per instruction.
// Holds mem_req/mem_addr until mem_gnt; holds id outputs stable while id_valid && !id_ready.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               LEN      = 32,
  parameter logic [LEN-1:0]   RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  output logic           mem_req,
  output logic [LEN-1:0] mem_addr,
  input  logic           mem_gnt,
  input  logic           mem_rvalid,
  input  logic [LEN-1:0] mem_rdata,
  input  logic           redirect_valid,
  input  logic [LEN-1:0] redirect_pc,
  output logic           id_valid,
  input  logic           id_ready,
  output logic [LEN-1:0] instruction,
  output logic [LEN-1:0] pc_out,
  output logic [5:0]     inst_type,
  output logic           illegal
);

  fetch_state_e   state_q, state_d;
  logic [LEN-1:0] pc_q, pc_d;
  logic [LEN-1:0] instr_q, instr_d;
  logic [LEN-1:0] pc_out_q, pc_out_d;
  logic [5:0]     type_q, type_d;
  logic           illegal_q, illegal_d;
  logic           id_valid_q, id_valid_d;
  logic [5:0]     dec_type;
  logic           dec_illegal;

  inst_predecode u_predecode (
    .opcode_i    (mem_rdata[6:0]),
    .inst_type_o (dec_type),
    .illegal_o   (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    type_d     = type_q;
    illegal_d  = illegal_q;
    id_valid_d = id_valid_q;

    if (redirect_valid && state_q != FS_IDLE) begin
      // A granted-but-unanswered request must be drained before refetching.
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
      case (state_q)
        FS_REQ:   state_d = mem_gnt    ? FS_DRAIN : FS_REQ;
        FS_WAIT:  state_d = mem_rvalid ? FS_REQ   : FS_DRAIN;
        FS_DRAIN: state_d = mem_rvalid ? FS_REQ   : FS_DRAIN;
        default:  state_d = FS_REQ;
      endcase
    end else begin
      case (state_q)
        FS_IDLE: state_d = FS_REQ;
        FS_REQ: begin
          if (mem_gnt) state_d = FS_WAIT;
        end
        FS_WAIT: begin
          if (mem_rvalid) begin
            instr_d    = mem_rdata;
            pc_out_d   = pc_q;
            type_d     = dec_type;
            illegal_d  = dec_illegal;
            id_valid_d = 1'b1;
            pc_d       = pc_q + LEN'(4);
            state_d    = FS_FULL;
          end
        end
        FS_FULL: begin
          if (id_ready) begin
            id_valid_d = 1'b0;
            state_d    = FS_REQ;
          end
        end
        FS_DRAIN: begin
          if (mem_rvalid) state_d = FS_REQ;
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_out_q   <= '0;
      type_q     <= '0;
      illegal_q  <= 1'b0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      type_q     <= type_d;
      illegal_q  <= illegal_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign mem_req     = (state_q == FS_REQ);
  assign mem_addr    = pc_q;
  assign id_valid    = id_valid_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign inst_type   = type_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized memory/decode environment
// checked against a sequential-PC-stream reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [5:0]  inst_type;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.LEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .inst_type      (inst_type),
    .illegal        (illegal)
  );

  // Opcode classification table straight from the instruction-type definitions.
  function automatic logic [5:0] ref_type(input logic [6:0] op);
    logic [5:0] t;
    t = 6'b000000;
    if (op == 7'b0110011) t = 6'b000001;
    if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b1110011) t = 6'b000010;
    if (op == 7'b0100011) t = 6'b000100;
    if (op == 7'b1100011) t = 6'b001000;
    if (op == 7'b0110111 || op == 7'b0010111) t = 6'b010000;
    if (op == 7'b1101111) t = 6'b100000;
    return t;
  endfunction

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    step; step;
    checks++;
    if (mem_req !== 1'b0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: mem_req=%b id_valid=%b, required 0 0", mem_req, id_valid);
    end
    checks++;
    if (instruction !== 32'h0 || pc_out !== 32'h0) begin
      errors++; $display("FAIL reset_data: instruction=%h pc_out=%h, required 0 0", instruction, pc_out);
    end
    checks++;
    if (inst_type !== 6'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_type: inst_type=%b illegal=%b, required 000000 0", inst_type, illegal);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_pc: mem_addr=%h, required 00000000", mem_addr);
    end
  endtask

  task automatic test_first_fetch;
    rst = 1'b0; mem_gnt = 1'b1;
    step;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: mem_req=%b mem_addr=%h, required 1 00000000", mem_req, mem_addr);
    end
    step;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL wait_req: mem_req=%b, required 0", mem_req);
    end
    step;
    mem_rvalid = 1'b0;
    checks++;
    if (id_valid !== 1'b1 || inst_type !== 6'b000010 || illegal !== 1'b0) begin
      errors++; $display("FAIL first_type: id_valid=%b inst_type=%b illegal=%b, required 1 000010 0", id_valid, inst_type, illegal);
    end
    checks++;
    if (pc_out !== 32'h0 || instruction !== 32'h0050_0093) begin
      errors++; $display("FAIL first_data: pc_out=%h instruction=%h, required 00000000 00500093", pc_out, instruction);
    end
    checks++;
    if (mem_addr !== 32'h4 || mem_req !== 1'b0) begin
      errors++; $display("FAIL first_next_pc: mem_addr=%h mem_req=%b, required 00000004 0", mem_addr, mem_req);
    end
  endtask

  task automatic test_stall;
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      checks++;
      if (id_valid !== 1'b1 || instruction !== 32'h0050_0093 || pc_out !== 32'h0 ||
          inst_type !== 6'b000010 || mem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: id_valid=%b instruction=%h pc_out=%h inst_type=%b mem_req=%b, required 1 00500093 00000000 000010 0",
                           i, id_valid, instruction, pc_out, inst_type, mem_req);
      end
    end
    id_ready = 1'b1;
    step;
    id_ready = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      errors++; $display("FAIL stall_release: id_valid=%b mem_req=%b mem_addr=%h, required 0 1 00000004", id_valid, mem_req, mem_addr);
    end
  endtask

  task automatic test_gnt_withheld;
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h4 || id_valid !== 1'b0) begin
        errors++; $display("FAIL gnt_hold[%0d]: mem_req=%b mem_addr=%h id_valid=%b, required 1 00000004 0", i, mem_req, mem_addr, id_valid);
      end
    end
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5037;
    step;
    mem_rvalid = 1'b0;
    checks++;
    if (id_valid !== 1'b1 || pc_out !== 32'h4 || instruction !== 32'h1234_5037 || inst_type !== 6'b010000) begin
      errors++; $display("FAIL gnt_fetch: id_valid=%b pc_out=%h instruction=%h inst_type=%b, required 1 00000004 12345037 010000",
                         id_valid, pc_out, instruction, inst_type);
    end
    id_ready = 1'b1;
    step;
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_wait;
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step;
    redirect_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL redir_drain: mem_req=%b id_valid=%b, required 0 0", mem_req, id_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step;
    mem_rvalid = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_refetch: id_valid=%b mem_req=%b mem_addr=%h, required 0 1 00000100", id_valid, mem_req, mem_addr);
    end
    checks++;
    if (instruction !== 32'h1234_5037) begin
      errors++; $display("FAIL redir_discard: instruction=%h, required 12345037", instruction);
    end
  endtask

  task automatic test_opcodes;
    logic [6:0]  ops  [6];
    logic [5:0]  exps [6];
    logic [31:0] r;
    logic [31:0] word;
    ops  = '{7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111, 7'b0110011, 7'b0000000};
    exps = '{6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001, 6'b000000};
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      word = {r[31:7], ops[i]};
      mem_gnt = 1'b1;
      step;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = word;
      step;
      mem_rvalid = 1'b0;
      checks++;
      if (id_valid !== 1'b1 || inst_type !== exps[i] || illegal !== (i == 5)) begin
        errors++; $display("FAIL opcode[%0d]: id_valid=%b inst_type=%b illegal=%b, required 1 %b %b",
                           i, id_valid, inst_type, illegal, exps[i], (i == 5));
      end
      checks++;
      if (instruction !== word || pc_out !== 32'h100 + 32'(4 * i)) begin
        errors++; $display("FAIL opcode_data[%0d]: instruction=%h pc_out=%h, required %h %h",
                           i, instruction, pc_out, word, 32'h100 + 32'(4 * i));
      end
      id_ready = 1'b1;
      step;
      id_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_wait;
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || id_valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0 ||
        inst_type !== 6'b0 || illegal !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL async_reset: mem_req=%b id_valid=%b instruction=%h pc_out=%h inst_type=%b illegal=%b mem_addr=%h, required all zero",
                         mem_req, id_valid, instruction, pc_out, inst_type, illegal, mem_addr);
    end
    step;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    step;
    checks++;
    if (id_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL late_rvalid: id_valid=%b mem_req=%b mem_addr=%h, required 0 1 00000000", id_valid, mem_req, mem_addr);
    end
    step;
    mem_rvalid = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rvalid_in_req: id_valid=%b mem_req=%b mem_addr=%h, required 0 1 00000000", id_valid, mem_req, mem_addr);
    end
  endtask

  // Model: requests and deliveries each follow base, base+4, ... restarting at every redirect;
  // each delivered word equals the memory image at its pc and carries the table type.
  task automatic test_random;
    logic [31:0] mem_img [logic [31:0]];
    logic [6:0]  op_tab [12];
    logic [31:0] exp_req, exp_del, pend_addr, tgt, r;
    logic [31:0] h_instr, h_pc, h_addr;
    logic [5:0]  h_type, et;
    logic        h_ill, hold_out, hold_req, pend, gnt_v, rv_v, rdy_v, redir_v;
    int          lat, deliveries;
    op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
               7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111, 7'b0001011};
    exp_req = 32'h0; exp_del = 32'h0; pend = 1'b0; lat = 0; deliveries = 0;
    hold_out = 1'b0; hold_req = 1'b0; pend_addr = '0;
    h_instr = '0; h_pc = '0; h_addr = '0; h_type = '0; h_ill = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold_out) begin
        checks++;
        if (id_valid !== 1'b1 || instruction !== h_instr || pc_out !== h_pc || inst_type !== h_type || illegal !== h_ill) begin
          errors++; $display("FAIL rnd_out_hold @%0d: id_valid=%b instruction=%h pc_out=%h inst_type=%b, required 1 %h %h %b",
                             cyc, id_valid, instruction, pc_out, inst_type, h_instr, h_pc, h_type);
        end
      end
      if (hold_req) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== h_addr) begin
          errors++; $display("FAIL rnd_req_hold @%0d: mem_req=%b mem_addr=%h, required 1 %h", cyc, mem_req, mem_addr, h_addr);
        end
      end
      if (pend && mem_req === 1'b1) begin
        errors++; checks++;
        $display("FAIL rnd_one_in_flight @%0d: mem_req=1 with a response outstanding, required 0", cyc);
      end

      rv_v = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          if (!mem_img.exists(pend_addr)) begin
            r = $urandom;
            mem_img[pend_addr] = {r[31:7], op_tab[$urandom_range(0, 11)]};
          end
          rv_v = 1'b1; mem_rdata = mem_img[pend_addr];
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rv_v = 1'b1; mem_rdata = $urandom;
      end
      gnt_v   = ($urandom_range(0, 2) != 0);
      rdy_v   = ($urandom_range(0, 1) != 0);
      redir_v = ($urandom_range(0, 24) == 0);
      tgt     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      if (redir_v) rdy_v = 1'b0;

      if (rv_v && pend) pend = 1'b0;
      if (mem_req === 1'b1 && gnt_v) begin
        checks++;
        if (mem_addr !== exp_req) begin
          errors++; $display("FAIL rnd_req_addr @%0d: mem_addr=%h, required %h", cyc, mem_addr, exp_req);
        end
        pend_addr = mem_addr; exp_req = exp_req + 32'd4;
        pend = 1'b1; lat = $urandom_range(0, 2);
      end
      if (id_valid === 1'b1 && rdy_v) begin
        deliveries++;
        checks++;
        if (pc_out !== exp_del || !mem_img.exists(pc_out) || instruction !== mem_img[pc_out]) begin
          errors++; $display("FAIL rnd_deliver @%0d: pc_out=%h instruction=%h, required pc %h with its memory word", cyc, pc_out, instruction, exp_del);
        end
        et = ref_type(instruction[6:0]);
        checks++;
        if (inst_type !== et || illegal !== (et == 6'b0)) begin
          errors++; $display("FAIL rnd_type @%0d: inst_type=%b illegal=%b, required %b %b", cyc, inst_type, illegal, et, (et == 6'b0));
        end
        exp_del = exp_del + 32'd4;
      end
      if (redir_v) begin
        exp_req = tgt; exp_del = tgt;
      end

      hold_out = (id_valid === 1'b1) && !rdy_v && !redir_v;
      hold_req = (mem_req === 1'b1) && !gnt_v && !redir_v;
      h_instr = instruction; h_pc = pc_out; h_type = inst_type; h_ill = illegal; h_addr = mem_addr;

      mem_rvalid = rv_v; mem_gnt = gnt_v; id_ready = rdy_v;
      redirect_valid = redir_v; redirect_pc = tgt;
      step;
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    checks++;
    if (deliveries < 50) begin
      errors++; $display("FAIL rnd_progress: deliveries=%0d, required at least 50", deliveries);
    end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_stall;
    test_gnt_withheld;
    test_redirect_wait;
    test_opcodes;
    test_reset_mid_wait;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
